// File: rtl/img_row_loader.sv
// Packs 16-bit pixel-pair words into a full-row buffer and writes each completed
// row to the image SRAM in a single cycle, flagging frame completion when done.
module img_row_loader #(
   parameter int ROW_BITS = 5120,
   parameter int WORD_W   = 16,
   parameter int NUM_ROWS = 480,
   parameter int ADDR_W   = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_data,
   output logic                in_ready,
   output logic                img_we,
   output logic [ADDR_W-1:0]   img_addr,
   output logic [ROW_BITS-1:0] img_din,
   output logic                busy,
   output logic                done,
   output logic                drop_err
);
   localparam int WORDS_PER_ROW = ROW_BITS / WORD_W;
   localparam int CNT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t                                state, state_nx;
   logic [CNT_W-1:0]                      word_cnt;
   logic [ADDR_W-1:0]                     row_cnt;
   logic [WORDS_PER_ROW-1:0][WORD_W-1:0]  row_buf;
   logic                                  accept;
   logic                                  idle_like;

   assign accept    = (state == FILL) && in_valid;
   assign idle_like = (state == IDLE) || (state == DONE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = FILL;
         FILL:    if (accept && word_cnt == LAST_WORD) state_nx = WRITE;
         WRITE:   state_nx = (row_cnt == LAST_ROW) ? DONE : FILL;
         DONE:    if (start) state_nx = FILL;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word_cnt <= '0;
         row_cnt  <= '0;
         row_buf  <= '0;
         drop_err <= 1'b0;
      end else begin
         state <= state_nx;
         // A new frame restarts addressing; otherwise stray input is only flagged.
         if (idle_like) begin
            if (start) begin
               word_cnt <= '0;
               row_cnt  <= '0;
               drop_err <= 1'b0;
            end else if (in_valid) begin
               drop_err <= 1'b1;
            end
         end
         if (accept) begin
            row_buf[word_cnt] <= in_data;
            word_cnt          <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
         end
         // row_cnt stays on the last row so img_addr holds it in DONE.
         if (state == WRITE && row_cnt != LAST_ROW)
            row_cnt <= row_cnt + 1'b1;
      end
   end

   assign in_ready = (state == FILL);
   assign img_we   = (state == WRITE);
   assign img_addr = row_cnt;
   assign img_din  = row_buf;
   assign busy     = (state == FILL) || (state == WRITE);
   assign done     = (state == DONE);
endmodule

// File: tb/tb_img_row_loader.sv
// Randomized bench for img_row_loader: a word-count level model predicts handshake,
// write timing and row contents; a reduced row count keeps frames short.
module tb_img_row_loader;
   localparam int ROW_BITS = 5120;
   localparam int WORD_W   = 16;
   localparam int NR       = 8;
   localparam int ADDR_W   = 9;
   localparam int WPR      = ROW_BITS / WORD_W;
   localparam int TOTAL    = NR * WPR;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic [WORD_W-1:0]   in_data = '0;
   logic                in_ready, img_we, busy, done, drop_err;
   logic [ADDR_W-1:0]   img_addr;
   logic [ROW_BITS-1:0] img_din;

   logic [WORD_W-1:0]   words [TOTAL];
   logic [ROW_BITS-1:0] mem   [NR];
   logic [ROW_BITS-1:0] gold  [NR];
   int n_chk  = 0;
   int n_fail = 0;

   img_row_loader #(.ROW_BITS(ROW_BITS), .WORD_W(WORD_W), .NUM_ROWS(NR), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .img_we(img_we), .img_addr(img_addr), .img_din(img_din),
      .busy(busy), .done(done), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Streams one frame; max_words >= 0 stops early once that many words are taken.
   task automatic run_frame(input int gap_pct, input int max_words, input bit spam_start,
                            input bit check_time);
      int acc, cyc, row;
      bit wr_pending, exp_rdy, exp_done, fin;
      logic [4:0] exp_v, got_v;
      logic [ROW_BITS-1:0] exp_row;
      acc = 0; cyc = 0; wr_pending = 0; fin = 0;
      start = 1'b1; in_valid = 1'b0;
      step();
      start = 1'b0;
      while (!fin) begin
         exp_rdy  = !wr_pending && (acc < TOTAL);
         exp_done = (acc == TOTAL) && !wr_pending;
         exp_v = {exp_rdy, wr_pending, !exp_done, exp_done, 1'b0};
         got_v = {in_ready, img_we, busy, done, drop_err};
         n_chk++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL frame_flags cyc=%0d acc=%0d {rdy,we,busy,done,drop} got=%b exp=%b",
                     cyc, acc, got_v, exp_v);
         end
         if (wr_pending) begin
            row = acc / WPR - 1;
            for (int w = 0; w < WPR; w++) exp_row[w*WORD_W +: WORD_W] = words[row*WPR + w];
            n_chk++;
            if (img_addr !== ADDR_W'(row)) begin
               n_fail++;
               $display("FAIL write_addr cyc=%0d got=%0d exp=%0d", cyc, img_addr, row);
            end
            n_chk++;
            if (img_din !== exp_row) begin
               n_fail++;
               $display("FAIL write_data row=%0d got[31:0]=%h exp[31:0]=%h", row,
                        img_din[31:0], exp_row[31:0]);
            end
            mem[row] = img_din;
         end
         if (exp_done) begin
            if (check_time) begin
               n_chk++;
               if (cyc !== NR * (WPR + 1)) begin
                  n_fail++;
                  $display("FAIL done_time got=%0d exp=%0d", cyc, NR * (WPR + 1));
               end
            end
            fin = 1;
         end else if (max_words >= 0 && acc == max_words && !wr_pending) begin
            fin = 1;
         end else begin
            in_valid = (acc < TOTAL) && ($urandom_range(99) >= gap_pct);
            if (acc < TOTAL) in_data = words[acc];
            start = spam_start && ($urandom_range(15) == 0);
            step();
            cyc++;
            if (in_valid && exp_rdy) begin
               acc++;
               wr_pending = (acc % WPR == 0);
            end else begin
               wr_pending = 0;
            end
            in_valid = 1'b0;
            start = 1'b0;
            if (cyc > 4 * TOTAL + 1000) begin
               n_chk++; n_fail++;
               $display("FAIL frame_timeout cyc=%0d acc=%0d exp_acc=%0d", cyc, acc, TOTAL);
               fin = 1;
            end
         end
      end
   endtask

   task automatic fill_rowword();
      for (int r = 0; r < NR; r++)
         for (int w = 0; w < WPR; w++) words[r*WPR + w] = {8'(r), 8'(w)};
   endtask

   task automatic fill_random();
      for (int i = 0; i < TOTAL; i++) words[i] = 16'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_chk++;
      if ({in_ready, img_we, busy, done, drop_err} !== 5'b0 || img_addr !== '0 || img_din !== '0) begin
         n_fail++;
         $display("FAIL reset_state flags=%b addr=%0d din_nonzero=%b exp=0",
                  {in_ready, img_we, busy, done, drop_err}, img_addr, |img_din);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_idle_drop();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if ({drop_err, img_we, in_ready, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_drop {drop,we,rdy,busy} got=%b exp=1000",
                     {drop_err, img_we, in_ready, busy});
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_full_frame();
      fill_rowword();
      run_frame(0, -1, 0, 1);
      for (int r = 0; r < NR; r++) gold[r] = mem[r];
   endtask

   task automatic test_done_drop();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_chk++;
      if ({drop_err, done, img_we, in_ready} !== 4'b1100 || img_addr !== ADDR_W'(NR - 1)) begin
         n_fail++;
         $display("FAIL done_drop {drop,done,we,rdy} got=%b exp=1100 addr=%0d exp=%0d",
                  {drop_err, done, img_we, in_ready}, img_addr, NR - 1);
      end
      step();
   endtask

   task automatic test_packing_restart();
      for (int i = 0; i < TOTAL; i++) words[i] = {8'(2*i + 2), 8'(2*i + 1)};
      run_frame(0, -1, 0, 1);
      n_chk++;
      if (mem[0][7:0] !== 8'h01 || mem[0][15:8] !== 8'h02 || mem[0][23:16] !== 8'h03) begin
         n_fail++;
         $display("FAIL packing_low got=%h exp=030201", mem[0][23:0]);
      end
      n_chk++;
      if (mem[0][5119:5104] !== 16'h807F) begin
         n_fail++;
         $display("FAIL packing_top got=%h exp=807f", mem[0][5119:5104]);
      end
   endtask

   task automatic test_bubbles();
      fill_rowword();
      run_frame(50, -1, 1, 0);
      for (int r = 0; r < NR; r++) begin
         n_chk++;
         if (mem[r] !== gold[r]) begin
            n_fail++;
            $display("FAIL bubble_row row=%0d got[31:0]=%h exp[31:0]=%h", r, mem[r][31:0],
                     gold[r][31:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_random();
      run_frame(0, -1, 0, 1);
   endtask

   task automatic test_reset_mid_frame();
      fill_random();
      run_frame(0, 6 * WPR + 100, 0, 0);
      rst = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b0;
      n_chk++;
      if ({in_ready, busy, img_we, done, drop_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL mid_reset {rdy,busy,we,done,drop} got=%b exp=00000",
                  {in_ready, busy, img_we, done, drop_err});
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if ({img_we, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_idle {we,busy} got=%b exp=00", {img_we, busy});
         end
      end
      fill_random();
      run_frame(30, -1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_idle_drop();
      test_full_frame();
      test_done_drop();
      test_packing_restart();
      test_bubbles();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/img_row_loader.md
Name: img_row_loader

Overview:
Front-end loader that fills the original-image SRAM (480 rows x 5120 bits, 640 8-bit pixels per row) from the 16-bit pixel input stream before the Gaussian stage runs. It packs two pixels per input word into a 5120-bit row register. It writes each completed row to the image SRAM in one cycle, then signals frame completion so the core FSM can leave idle and start blurring. It applies backpressure through in_ready while a row is being written.

Parameters:
ROW_BITS, 5120, bits per SRAM row (640 pixels x 8 bits)
WORD_W, 16, input word width (2 pixels)
NUM_ROWS, 480, rows per frame
ADDR_W, 9, SRAM row-address width
WORDS_PER_ROW, ROW_BITS/WORD_W = 320, derived, not overridable

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; begins loading a frame
in_valid  in  1  input word valid
in_data  in  16  [7:0] = pixel at even column 2k, [15:8] = pixel at odd column 2k+1
in_ready  out  1  word accepted on a cycle where in_valid & in_ready
img_we  out  1  image SRAM write enable
img_addr  out  9  image SRAM row address
img_din  out  5120  image SRAM row write data
busy  out  1  high in FILL or WRITE
done  out  1  frame fully written; level signal
drop_err  out  1  sticky flag: in_valid seen while not accepting outside WRITE

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, word_cnt=0, row_cnt=0, row_buf=0, drop_err=0.
- Reset values of outputs: in_ready=0, img_we=0, img_addr=0, img_din=0, busy=0, done=0.
- Reset mid-frame abandons the frame. No further img_we is issued and rows already written are not cleared.
- States: IDLE, FILL, WRITE, DONE. All outputs decode from registered state and counters; there are no combinational paths from inputs to outputs.
- IDLE: in_ready=0. start -> FILL, clearing word_cnt, row_cnt and drop_err.
- FILL: in_ready=1. Each accepted word is written to row_buf[16*word_cnt+15 : 16*word_cnt], then word_cnt increments.
  - Accepting with word_cnt==319 -> WRITE, and word_cnt wraps to 0.
  - No accept -> stay in FILL; gaps of any length are allowed.
- WRITE (exactly 1 cycle): img_we=1, img_addr=row_cnt, img_din=row_buf, in_ready=0.
  - Next state is DONE if row_cnt==479, else FILL with row_cnt+1.
  - row_buf is not cleared; every slot is overwritten before the next write.
- DONE: done=1, in_ready=0, img_addr holds 479. start -> FILL for a new frame and clears done and drop_err.
- Latency: the word accepted at edge N with word_cnt==319 produces img_we high during the cycle after edge N. The SRAM commits at edge N+1.
- Minimum frame time: 480 x 321 = 154080 cycles after start.
- start while in FILL or WRITE is ignored and does not restart the frame.
- drop_err is set on any cycle with in_valid=1 in IDLE or DONE; the data is discarded. It stays set until start or rst.
- in_valid=1 in WRITE is normal backpressure: the word is held by the source and does not set drop_err.
- Simultaneous rst and start: reset wins.

Test Plan:
- Full frame: start, then 153600 words with in_data = {row[7:0], word[7:0]}, in_valid always high.
  - Required: 480 img_we pulses with img_addr 0..479 in order, each one cycle after that row's 320th accept.
  - Required: in_ready low exactly on those cycles; done rises at cycle 154080 after start.
- Packing order: row 0 words 0x0201, 0x0403, ... -> img_din[7:0]=0x01, [15:8]=0x02, [23:16]=0x03; word 319 lands at [5119:5104].
- Bubbles: random in_valid gaps (~50% density) -> SRAM contents identical to the gap-free run; no word lost or duplicated.
- Backpressure: hold in_valid=1 with word 320 of row 0 (first word of row 1) through the WRITE cycle -> word accepted on the following cycle into slot 0 of row 1; drop_err stays 0.
- Errors and restart: in_valid=1 in IDLE -> drop_err=1, no img_we. start clears drop_err. start again in DONE reloads a new frame from row 0.
- Reset mid-frame: assert rst after row 5, word 100 -> next cycle in_ready=0, busy=0, no img_we. A subsequent start writes row 0 first.
